shifta_txn_sequencer: RTL and testbench
=======================================

# shifta_txn_sequencer

Run scheduler for the shiftA AXI master test engine. It issues a programmable number of INIT_AXI_TXN pulses with a configurable idle gap between runs, and waits for TXN_DONE on each run. It classifies each run as pass, fail or timeout, and keeps saturating result counters. It sits between the system control logic and the IP's INIT_AXI_TXN / TXN_DONE / ERROR handshake, and replaces the single manual init pulse.

## Interface
- CNT_WIDTH, 8: width of NUM_RUNS and of all result counters
- GAP_WIDTH, 16: width of GAP_CYCLES
- INIT_PULSE_CYCLES, 2: INIT_AXI_TXN high time in cycles, legal range ≥1
- TIMEOUT_CYCLES, 4096: maximum WAIT cycles per run, legal range ≥2

Ports:
- ACLK  in  1  clock; all logic is on the rising edge
- ARESET  in  1  reset, synchronous, active-high
- START  in  1  start request; accepted only in IDLE
- ABORT  in  1  cancels the active sequence
- NUM_RUNS  in  CNT_WIDTH  number of runs; sampled when START is accepted
- GAP_CYCLES  in  GAP_WIDTH  idle cycles between runs; sampled when START is accepted
- INIT_AXI_TXN  out  1  registered init pulse to the IP
- TXN_DONE  in  1  IP completion level
- ERROR  in  1  IP error flag; valid with the TXN_DONE rising edge
- BUSY  out  1  high whenever state ≠ IDLE
- DONE  out  1  one-cycle pulse when the sequence completes
- PASS_CNT  out  CNT_WIDTH  runs that ended with ERROR=0
- FAIL_CNT  out  CNT_WIDTH  runs that ended with ERROR=1
- TMO_CNT  out  CNT_WIDTH  runs that hit the watchdog
- ANY_FAIL  out  1  sticky; set by any fail or timeout

## Operation
- States: IDLE, INIT, WAIT, GAP, FINISH.
- IDLE, START=1, ABORT=0:
  - Latch NUM_RUNS into remaining and GAP_CYCLES into gap_len.
  - Clear PASS_CNT, FAIL_CNT, TMO_CNT and ANY_FAIL.
  - Next state is INIT, or FINISH if NUM_RUNS=0.
- INIT:
  - INIT_AXI_TXN=1 for exactly INIT_PULSE_CYCLES cycles, then go to WAIT.
  - The watchdog counter is cleared on entry to WAIT.
- Edge detect: done_q <= TXN_DONE every cycle, reset value 0. done_rise = TXN_DONE & ~done_q. A done_rise in any state other than WAIT is ignored.
- WAIT, done_rise=1:
  - ERROR=0 increments PASS_CNT.
  - ERROR=1 increments FAIL_CNT and sets ANY_FAIL.
  - remaining is decremented.
- WAIT, no done_rise, watchdog = TIMEOUT_CYCLES−1:
  - Increment TMO_CNT, set ANY_FAIL, decrement remaining.
- When a WAIT run ends by either path:
  - Go to FINISH if remaining becomes 0.
  - Otherwise go to GAP, or directly to INIT if gap_len=0.
- GAP: wait exactly gap_len cycles, then go to INIT.
- FINISH: DONE=1 for one cycle, then go to IDLE. Counters hold their values until the next accepted START.
- Counters saturate at 2^CNT_WIDTH−1; the run still completes normally.
- ABORT=1 in any non-IDLE state:
  - Next state is IDLE and INIT_AXI_TXN drops next cycle.
  - DONE is not pulsed; counters hold.
- ABORT wins over START in the same cycle.
- START outside IDLE is ignored.
- ARESET=1 in any state, including mid-run:
  - All outputs are 0 next cycle, state goes to IDLE, done_q=0.
  - The IP transaction in flight is not tracked further.

## Timing
- START accepted at edge k:
  - BUSY=1 and INIT_AXI_TXN=1 from cycle k+1.
  - INIT_AXI_TXN stays high through cycle k+INIT_PULSE_CYCLES.
  - WAIT starts at k+INIT_PULSE_CYCLES+1.
- done_rise sampled at edge t in WAIT:
  - Counter update is visible at t+1.
  - Next state (GAP, INIT or FINISH) is entered at t+1.
- Same-cycle collision: a done_rise in the watchdog's last cycle is counted as pass or fail, not as a timeout.
- The gap between the last INIT_AXI_TXN high cycle of one run and the first of the next is ≥ gap_len+2 cycles.
- DONE and BUSY:
  - DONE is high in the single FINISH cycle; BUSY is still 1 in that cycle.
  - BUSY=0 the following cycle.
- Reset values: INIT_AXI_TXN=0, BUSY=0, DONE=0, PASS_CNT=FAIL_CNT=TMO_CNT=0, ANY_FAIL=0.

## Test plan
- Basic passes:
  - Stimulus: NUM_RUNS=3, GAP_CYCLES=5. The IP model raises TXN_DONE 20 cycles after each init with ERROR=0.
  - Response: three 2-cycle INIT pulses, PASS_CNT=3, FAIL_CNT=0, ANY_FAIL=0, one DONE pulse, BUSY low the cycle after DONE.
- Error classification:
  - Stimulus: NUM_RUNS=4, with ERROR=1 on runs 2 and 4.
  - Response: PASS_CNT=2, FAIL_CNT=2, ANY_FAIL=1.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=16, NUM_RUNS=2, TXN_DONE never rises.
  - Response: TMO_CNT=2, each WAIT lasts exactly 16 cycles, DONE pulses. A TXN_DONE rise in the 16th WAIT cycle gives PASS_CNT+1, TMO_CNT unchanged.
- Zero cases:
  - NUM_RUNS=0: DONE one cycle after START, no INIT pulse, counters 0.
  - GAP_CYCLES=0: INIT is re-entered on the cycle after done_rise.
- ABORT and reset:
  - ABORT during run 2 of 5: IDLE next cycle, no DONE, PASS_CNT=1 held.
  - START and ABORT together in IDLE: start ignored.
  - ARESET mid-WAIT: all outputs 0 next cycle.
- Saturation:
  - Stimulus: CNT_WIDTH=2, NUM_RUNS=3, all runs pass.
  - Response: PASS_CNT=3. Then NUM_RUNS=0 with START clears the counters.

Source files
------------

// File: rtl/shifta_txn_sequencer.sv
// rtl/shifta_txn_sequencer.sv - run scheduler issuing INIT_AXI_TXN pulses and classifying TXN_DONE/ERROR results
module shifta_txn_sequencer #(
    parameter int CNT_WIDTH         = 8,
    parameter int GAP_WIDTH         = 16,
    parameter int INIT_PULSE_CYCLES = 2,
    parameter int TIMEOUT_CYCLES    = 4096
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic                 START,
    input  logic                 ABORT,
    input  logic [CNT_WIDTH-1:0] NUM_RUNS,
    input  logic [GAP_WIDTH-1:0] GAP_CYCLES,
    output logic                 INIT_AXI_TXN,
    input  logic                 TXN_DONE,
    input  logic                 ERROR,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [CNT_WIDTH-1:0] PASS_CNT,
    output logic [CNT_WIDTH-1:0] FAIL_CNT,
    output logic [CNT_WIDTH-1:0] TMO_CNT,
    output logic                 ANY_FAIL
);

    localparam int PW = (INIT_PULSE_CYCLES > 1) ? $clog2(INIT_PULSE_CYCLES) : 1;
    localparam int WW = $clog2(TIMEOUT_CYCLES);
    localparam logic [PW-1:0] PULSE_LAST = PW'(INIT_PULSE_CYCLES - 1);
    localparam logic [WW-1:0] WD_LAST    = WW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INIT   = 3'd1,
        S_WAIT   = 3'd2,
        S_GAP    = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic                   done_q;
    logic [CNT_WIDTH-1:0]   remaining;
    logic [GAP_WIDTH-1:0]   gap_len;
    logic [GAP_WIDTH-1:0]   gap_cnt;
    logic [PW-1:0]          pulse_cnt;
    logic [WW-1:0]          wd_cnt;

    logic done_rise;
    logic pulse_last;
    logic wd_last;
    logic gap_last;
    logic run_end;
    logic start_ok;

    assign done_rise  = TXN_DONE & ~done_q;
    assign pulse_last = (pulse_cnt == PULSE_LAST);
    assign wd_last    = (wd_cnt == WD_LAST);
    assign gap_last   = (gap_cnt == gap_len - GAP_WIDTH'(1));
    // A run ends on the IP's completion edge; the watchdog only fires when no edge arrives in its last cycle.
    assign run_end    = (state == S_WAIT) & (done_rise | wd_last);
    assign start_ok   = (state == S_IDLE) & START & ~ABORT;

    // State register.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state selection; ABORT overrides every transition and also masks START in IDLE.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (START) begin
                    next_state = (NUM_RUNS == '0) ? S_FINISH : S_INIT;
                end
            end
            S_INIT: begin
                if (pulse_last) begin
                    next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (done_rise || wd_last) begin
                    if (remaining == CNT_WIDTH'(1)) begin
                        next_state = S_FINISH;
                    end else if (gap_len == '0) begin
                        next_state = S_INIT;
                    end else begin
                        next_state = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (gap_last) begin
                    next_state = S_INIT;
                end
            end
            S_FINISH: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
        if (ABORT) begin
            next_state = S_IDLE;
        end
    end

    // Outputs decoded from the registered state so they change only on clock edges.
    always_comb begin
        INIT_AXI_TXN = 1'b0;
        BUSY         = 1'b0;
        DONE         = 1'b0;
        INIT_AXI_TXN = (state == S_INIT);
        BUSY         = (state != S_IDLE);
        DONE         = (state == S_FINISH);
    end

    // Phase timers: each counts only while its own state is active and sits at zero otherwise,
    // so every entry into INIT, WAIT or GAP starts from a cleared count.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            pulse_cnt <= '0;
            wd_cnt    <= '0;
            gap_cnt   <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q    <= TXN_DONE;
            pulse_cnt <= (state == S_INIT) ? pulse_cnt + PW'(1) : '0;
            wd_cnt    <= (state == S_WAIT) ? wd_cnt + WW'(1) : '0;
            gap_cnt   <= (state == S_GAP) ? gap_cnt + GAP_WIDTH'(1) : '0;
        end
    end

    // Sequence parameters and saturating result counters; an aborted cycle leaves them untouched.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            remaining <= '0;
            gap_len   <= '0;
            PASS_CNT  <= '0;
            FAIL_CNT  <= '0;
            TMO_CNT   <= '0;
            ANY_FAIL  <= 1'b0;
        end else if (start_ok) begin
            remaining <= NUM_RUNS;
            gap_len   <= GAP_CYCLES;
            PASS_CNT  <= '0;
            FAIL_CNT  <= '0;
            TMO_CNT   <= '0;
            ANY_FAIL  <= 1'b0;
        end else if (run_end && !ABORT) begin
            remaining <= remaining - CNT_WIDTH'(1);
            if (done_rise) begin
                if (ERROR) begin
                    if (FAIL_CNT != '1) begin
                        FAIL_CNT <= FAIL_CNT + CNT_WIDTH'(1);
                    end
                    ANY_FAIL <= 1'b1;
                end else if (PASS_CNT != '1) begin
                    PASS_CNT <= PASS_CNT + CNT_WIDTH'(1);
                end
            end else begin
                if (TMO_CNT != '1) begin
                    TMO_CNT <= TMO_CNT + CNT_WIDTH'(1);
                end
                ANY_FAIL <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_shifta_txn_sequencer.sv
// tb/tb_shifta_txn_sequencer.sv - randomized self-checking bench for shifta_txn_sequencer
module tb_shifta_txn_sequencer;

    localparam int CW   = 3;
    localparam int GW   = 4;
    localparam int IPC  = 2;
    localparam int TMO  = 16;
    localparam int MAXV = 7;
    localparam int MAXC = 16384;

    logic          ACLK = 1'b0;
    logic          ARESET = 1'b1;
    logic          START = 1'b0;
    logic          ABORT = 1'b0;
    logic [CW-1:0] NUM_RUNS = '0;
    logic [GW-1:0] GAP_CYCLES = '0;
    logic          TXN_DONE = 1'b0;
    logic          ERROR = 1'b0;
    logic          INIT_AXI_TXN;
    logic          BUSY;
    logic          DONE;
    logic [CW-1:0] PASS_CNT;
    logic [CW-1:0] FAIL_CNT;
    logic [CW-1:0] TMO_CNT;
    logic          ANY_FAIL;

    shifta_txn_sequencer #(
        .CNT_WIDTH(CW), .GAP_WIDTH(GW), .INIT_PULSE_CYCLES(IPC), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET), .START(START), .ABORT(ABORT),
        .NUM_RUNS(NUM_RUNS), .GAP_CYCLES(GAP_CYCLES), .INIT_AXI_TXN(INIT_AXI_TXN),
        .TXN_DONE(TXN_DONE), .ERROR(ERROR), .BUSY(BUSY), .DONE(DONE),
        .PASS_CNT(PASS_CNT), .FAIL_CNT(FAIL_CNT), .TMO_CNT(TMO_CNT), .ANY_FAIL(ANY_FAIL)
    );

    always #5 ACLK = ~ACLK;

    // Planned stimulus per cycle (cycle c = interval following rising edge c).
    bit drv_start[MAXC];
    bit drv_abort[MAXC];
    bit drv_reset[MAXC];
    bit drv_done[MAXC];
    bit drv_err[MAXC];
    int drv_n[MAXC];
    int drv_g[MAXC];

    // Expected outputs per cycle.
    bit exp_init[MAXC];
    bit exp_busy[MAXC];
    bit exp_done[MAXC];
    bit exp_any[MAXC];
    int exp_p[MAXC];
    int exp_f[MAXC];
    int exp_t[MAXC];

    int cyc = 0;
    int filled = -1;
    int cur_p = 0, cur_f = 0, cur_t = 0;
    bit cur_any = 0;
    int n_tests = 0, n_fail = 0;
    int run_d[8];
    int run_l[8];
    bit run_e[8];

    function automatic int sat(input int v);
        return (v >= MAXV) ? MAXV : v + 1;
    endfunction

    task automatic set_exp(input int c, input bit i, input bit b, input bit d);
        exp_init[c] = i;
        exp_busy[c] = b;
        exp_done[c] = d;
        exp_p[c]    = cur_p;
        exp_f[c]    = cur_f;
        exp_t[c]    = cur_t;
        exp_any[c]  = cur_any;
    endtask

    task automatic fill_idle(input int upto);
        for (int c = filled + 1; c <= upto; c++) set_exp(c, 1'b0, 1'b0, 1'b0);
        if (upto > filled) filled = upto;
    endtask

    // Schedule one accepted sequence starting at cycle k. kill: 0 none, 1 ABORT, 2 ARESET at k+1+kill_off.
    task automatic plan_seq(input int k, input int n, input int gap, input int kill, input int kill_off,
                            output int fin, output int endc);
        int c, s, w, e, tail, a;
        bit hit;
        if (filled < k) fill_idle(k);
        drv_start[k] = 1'b1;
        drv_n[k] = n;
        drv_g[k] = gap;
        cur_p = 0; cur_f = 0; cur_t = 0; cur_any = 1'b0;
        c = k + 1;
        tail = k;
        fin = k + 1;
        for (int i = 0; i < n; i++) begin
            s = c;
            for (int j = 0; j < IPC; j++) set_exp(s + j, 1'b1, 1'b1, 1'b0);
            for (int j = 0; j < run_l[i]; j++) begin
                drv_done[s + run_d[i] + j] = 1'b1;
                drv_err[s + run_d[i] + j]  = run_e[i];
                if (s + run_d[i] + j > tail) tail = s + run_d[i] + j;
            end
            w = s + IPC;
            hit = 1'b0;
            e = w + TMO - 1;
            for (int cc = w; cc < w + TMO; cc++) begin
                set_exp(cc, 1'b0, 1'b1, 1'b0);
                if (drv_done[cc] && !drv_done[cc - 1]) begin
                    hit = 1'b1;
                    e = cc;
                    break;
                end
            end
            if (hit) begin
                if (drv_err[e]) begin cur_f = sat(cur_f); cur_any = 1'b1; end
                else cur_p = sat(cur_p);
            end else begin
                cur_t = sat(cur_t);
                cur_any = 1'b1;
            end
            if (i == n - 1) fin = e + 1;
            else begin
                for (int g = 1; g <= gap; g++) set_exp(e + g, 1'b0, 1'b1, 1'b0);
                c = e + gap + 1;
            end
        end
        set_exp(fin, 1'b0, 1'b1, 1'b1);
        filled = fin;
        if (kill != 0) begin
            a = k + 1 + kill_off;
            if (a > fin) a = fin;
            if (kill == 1) begin
                drv_abort[a] = 1'b1;
                cur_p = exp_p[a]; cur_f = exp_f[a]; cur_t = exp_t[a]; cur_any = exp_any[a];
            end else begin
                drv_reset[a] = 1'b1;
                cur_p = 0; cur_f = 0; cur_t = 0; cur_any = 1'b0;
            end
            for (int cc = a + 1; cc <= fin; cc++) set_exp(cc, 1'b0, 1'b0, 1'b0);
        end
        endc = (tail > fin) ? tail + 1 : fin + 1;
        fill_idle(endc + 64);
    endtask

    task automatic chk(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic wait_neg(input int c);
        while (cyc < c) @(negedge ACLK);
    endtask

    task automatic set_runs(input int d, input int l);
        for (int i = 0; i < 8; i++) begin run_d[i] = d; run_l[i] = l; run_e[i] = 1'b0; end
    endtask

    // Driver: applies the planned stimulus 1 time unit after each rising edge, with junk on don't-care inputs.
    initial begin
        forever begin
            @(posedge ACLK);
            cyc = cyc + 1;
            #1;
            ARESET     = drv_reset[cyc];
            START      = drv_start[cyc] | (exp_busy[cyc] & ($urandom_range(0, 3) == 0));
            ABORT      = drv_abort[cyc] | (!exp_busy[cyc] && !drv_start[cyc] && ($urandom_range(0, 7) == 0));
            NUM_RUNS   = drv_start[cyc] ? CW'(drv_n[cyc]) : CW'($urandom);
            GAP_CYCLES = drv_start[cyc] ? GW'(drv_g[cyc]) : GW'($urandom);
            TXN_DONE   = drv_done[cyc];
            ERROR      = drv_done[cyc] ? drv_err[cyc] : ($urandom_range(0, 1) == 1);
        end
    end

    // Cycle-by-cycle comparison on the falling edge.
    initial begin
        forever begin
            @(negedge ACLK);
            if (cyc >= 1) begin
                n_tests++;
                if (INIT_AXI_TXN !== exp_init[cyc] || BUSY !== exp_busy[cyc] || DONE !== exp_done[cyc] ||
                    PASS_CNT !== CW'(exp_p[cyc]) || FAIL_CNT !== CW'(exp_f[cyc]) ||
                    TMO_CNT !== CW'(exp_t[cyc]) || ANY_FAIL !== exp_any[cyc]) begin
                    n_fail++;
                    $display("FAIL cycle %0d: got init=%0b busy=%0b done=%0b pass=%0d fail=%0d tmo=%0d any=%0b, expected init=%0b busy=%0b done=%0b pass=%0d fail=%0d tmo=%0d any=%0b",
                             cyc, INIT_AXI_TXN, BUSY, DONE, PASS_CNT, FAIL_CNT, TMO_CNT, ANY_FAIL,
                             exp_init[cyc], exp_busy[cyc], exp_done[cyc], exp_p[cyc], exp_f[cyc],
                             exp_t[cyc], exp_any[cyc]);
                end
            end
        end
    end

    initial begin
        #3000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        int k, fin, endc, n, gap, kill, off;
        for (int c = 0; c < 4; c++) drv_reset[c] = 1'b1;
        fill_idle(80);

        // Reset values.
        wait_neg(5);
        chk("reset_busy", int'(BUSY), 0);
        chk("reset_pass", int'(PASS_CNT), 0);

        // Basic passes: 3 runs, gap 5, completion 10 cycles after each init start.
        k = 10;
        set_runs(10, 2);
        plan_seq(k, 3, 5, 0, 0, fin, endc);
        chk("basic_model_fin", fin - k, 44);
        wait_neg(k + 1); chk("basic_init_k1", int'(INIT_AXI_TXN), 1);
        wait_neg(k + 2); chk("basic_init_k2", int'(INIT_AXI_TXN), 1);
        wait_neg(k + 3); chk("basic_init_k3", int'(INIT_AXI_TXN), 0);
        wait_neg(fin);
        chk("basic_done", int'(DONE), 1);
        chk("basic_pass", int'(PASS_CNT), 3);
        chk("basic_any", int'(ANY_FAIL), 0);
        wait_neg(fin + 1); chk("basic_busy_after", int'(BUSY), 0);

        // Error classification: runs 2 and 4 report ERROR.
        k = endc + 2;
        set_runs(8, 1);
        run_e[1] = 1'b1; run_e[3] = 1'b1;
        plan_seq(k, 4, 2, 0, 0, fin, endc);
        wait_neg(fin);
        chk("err_pass", int'(PASS_CNT), 2);
        chk("err_fail", int'(FAIL_CNT), 2);
        chk("err_any", int'(ANY_FAIL), 1);

        // Timeout: TXN_DONE never rises.
        k = endc + 2;
        set_runs(0, 0);
        plan_seq(k, 2, 0, 0, 0, fin, endc);
        chk("tmo_model_fin", fin - k, 37);
        wait_neg(fin);
        chk("tmo_cnt", int'(TMO_CNT), 2);
        chk("tmo_done", int'(DONE), 1);

        // Rise in the watchdog's last WAIT cycle counts as a pass.
        k = endc + 2;
        set_runs(17, 2);
        plan_seq(k, 1, 0, 0, 0, fin, endc);
        chk("collide_model_fin", fin - k, 19);
        wait_neg(fin);
        chk("collide_pass", int'(PASS_CNT), 1);
        chk("collide_tmo", int'(TMO_CNT), 0);

        // NUM_RUNS = 0.
        k = endc + 2;
        plan_seq(k, 0, 3, 0, 0, fin, endc);
        wait_neg(k + 1);
        chk("zero_done", int'(DONE), 1);
        chk("zero_init", int'(INIT_AXI_TXN), 0);
        chk("zero_pass", int'(PASS_CNT), 0);

        // GAP_CYCLES = 0: INIT re-entered the cycle after done_rise.
        k = endc + 2;
        set_runs(5, 1);
        plan_seq(k, 2, 0, 0, 0, fin, endc);
        wait_neg(k + 6); chk("gap0_init_before", int'(INIT_AXI_TXN), 0);
        wait_neg(k + 7); chk("gap0_init_after", int'(INIT_AXI_TXN), 1);
        wait_neg(endc);

        // ABORT during run 2 of 5.
        k = endc + 2;
        set_runs(10, 1);
        plan_seq(k, 5, 3, 1, 19, fin, endc);
        wait_neg(k + 21);
        chk("abort_busy", int'(BUSY), 0);
        chk("abort_pass", int'(PASS_CNT), 1);

        // START together with ABORT in IDLE is ignored.
        k = cyc + 3;
        drv_start[k] = 1'b1; drv_abort[k] = 1'b1; drv_n[k] = 3; drv_g[k] = 1;
        fill_idle(k + 64);
        wait_neg(k + 1);
        chk("sa_busy", int'(BUSY), 0);
        chk("sa_pass_held", int'(PASS_CNT), 1);
        endc = k + 1;

        // ARESET in run 2's WAIT.
        k = endc + 2;
        set_runs(10, 1);
        plan_seq(k, 3, 1, 2, 16, fin, endc);
        wait_neg(k + 17); chk("rst_pass_before", int'(PASS_CNT), 1);
        wait_neg(k + 18);
        chk("rst_busy", int'(BUSY), 0);
        chk("rst_pass", int'(PASS_CNT), 0);
        chk("rst_init", int'(INIT_AXI_TXN), 0);

        // Counter ceiling, then NUM_RUNS=0 clears the counters.
        k = endc + 2;
        set_runs(4, 1);
        plan_seq(k, 7, 0, 0, 0, fin, endc);
        wait_neg(fin); chk("sat_pass", int'(PASS_CNT), 7);
        k = endc + 2;
        plan_seq(k, 0, 0, 0, 0, fin, endc);
        wait_neg(k + 1); chk("sat_clear", int'(PASS_CNT), 0);

        // Randomized sequences.
        for (int r = 0; r < 30; r++) begin
            wait_neg(endc);
            k = endc + 1 + $urandom_range(0, 3);
            if (k < cyc + 2) k = cyc + 2;
            n = $urandom_range(0, 7);
            gap = $urandom_range(0, 5);
            for (int i = 0; i < 8; i++) begin
                run_d[i] = $urandom_range(0, 22);
                run_l[i] = $urandom_range(1, 3);
                run_e[i] = ($urandom_range(0, 2) == 0);
            end
            off = $urandom_range(0, 60);
            case ($urandom_range(0, 9))
                0: kill = 1;
                1: kill = 2;
                default: kill = 0;
            endcase
            plan_seq(k, n, gap, kill, off, fin, endc);
        end
        wait_neg(endc + 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
